// File: rtl/music_box_pkg.sv
// Shared definitions for the music box datapath.
//
// Contents:
//   SAMPLE_RATE, FREQ_W, AMP_W, DUR_W  - sample rate and bus widths
//   seq_state_t                         - note sequencer FSM states
//   note_entry_t                        - one note ROM entry {freq, dur}
//   sat_add / sat_sub                   - saturating amplitude arithmetic
package music_box_pkg;

  localparam int SAMPLE_RATE = 32000;
  localparam int FREQ_W      = 14;
  localparam int AMP_W       = 8;
  localparam int DUR_W       = 8;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    LOAD,
    ALIGN,
    ATTACK,
    SUSTAIN,
    RELEASE,
    ADVANCE,
    END
  } seq_state_t;

  typedef struct packed {
    logic [FREQ_W-1:0] freq;
    logic [DUR_W-1:0]  dur;
  } note_entry_t;

  // Add with clamp at full scale instead of wrapping.
  function automatic logic [AMP_W-1:0] sat_add(input logic [AMP_W-1:0] a,
                                               input logic [AMP_W-1:0] b);
    logic [AMP_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[AMP_W] ? '1 : sum[AMP_W-1:0];
  endfunction

  // Subtract with clamp at zero instead of wrapping.
  function automatic logic [AMP_W-1:0] sat_sub(input logic [AMP_W-1:0] a,
                                               input logic [AMP_W-1:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction

endpackage

// File: rtl/envelope_ramp.sv
// Saturating 8-bit up/down ramp used as the note amplitude envelope.
//
// Ports:
//   CLK_32KHz  in   sample clock
//   reset_n    in   asynchronous, active-low reset
//   tick       in   one-cycle step enable
//   rampUp     in   step upwards on tick (clamps at full scale)
//   rampDown   in   step downwards on tick (clamps at zero)
//   step       in   step size
//   clear      in   force the level to zero (highest priority)
//   level      out  current envelope level
//   atMax      out  level is at full scale
//   atMin      out  level is zero
module envelope_ramp
  import music_box_pkg::*;
(
  input  logic             CLK_32KHz,
  input  logic             reset_n,
  input  logic             tick,
  input  logic             rampUp,
  input  logic             rampDown,
  input  logic [AMP_W-1:0] step,
  input  logic             clear,
  output logic [AMP_W-1:0] level,
  output logic             atMax,
  output logic             atMin
);

  always_ff @(posedge CLK_32KHz or negedge reset_n) begin
    if (!reset_n) begin
      level <= '0;
    end else if (clear) begin
      level <= '0;
    end else if (tick && rampUp) begin
      level <= sat_add(level, step);
    end else if (tick && rampDown) begin
      level <= sat_sub(level, step);
    end
  end

  assign atMax = (level == '1);
  assign atMin = (level == '0);

endmodule

// File: rtl/note_sequencer.sv
// Note sequencer: walks an external synchronous note ROM of (frequency,
// duration) entries and drives the sine generator's frequency and amplitude
// with a linear attack/sustain/release envelope. New frequencies are applied
// only at the generator's phase zero so note changes are click-free.
//
// Optional build macro: NOTE_SEQUENCER_TEMPO_EN adds tempoSelect[1:0], which
// divides the tick period by 1/2/4/8 (sampled only when the tick counter wraps).
//
// Ports:
//   CLK_32KHz        in   sample clock
//   reset_n          in   asynchronous, active-low reset
//   start            in   begin song at entry 0 (ignored while busy)
//   stop             in   abort song at once (wins over start)
//   loopEnable       in   restart at entry 0 at end of song
//   indexZero        in   generator phase-zero flag
//   tempoSelect      in   tempo multiplier select (only with the macro)
//   noteAddress      out  ROM address
//   noteFrequency    in   ROM data, Hz (0 = rest)
//   noteDuration     in   ROM data, ticks (0 = end-of-song marker)
//   outputFrequency  out  generator frequency
//   outputAmplitude  out  generator amplitude
//   busy             out  high in every state except IDLE
//   songDone         out  one-cycle pulse at song end
module note_sequencer
  import music_box_pkg::*;
#(
  parameter int NOTE_COUNT   = 16,
  parameter int TICK_DIV     = 320,
  parameter int ATTACK_STEP  = 16,
  parameter int RELEASE_STEP = 8
) (
  input  logic                          CLK_32KHz,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic                          stop,
  input  logic                          loopEnable,
  input  logic                          indexZero,
`ifdef NOTE_SEQUENCER_TEMPO_EN
  input  logic [1:0]                    tempoSelect,
`endif
  output logic [$clog2(NOTE_COUNT)-1:0] noteAddress,
  input  logic [FREQ_W-1:0]             noteFrequency,
  input  logic [DUR_W-1:0]              noteDuration,
  output logic [FREQ_W-1:0]             outputFrequency,
  output logic [AMP_W-1:0]              outputAmplitude,
  output logic                          busy,
  output logic                          songDone
);

  localparam int ADDR_W = $clog2(NOTE_COUNT);
  localparam int TICK_W = ($clog2(TICK_DIV) > 0) ? $clog2(TICK_DIV) : 1;
  localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(NOTE_COUNT - 1);
  localparam logic [TICK_W-1:0] ALIGN_LAST = TICK_W'(TICK_DIV - 1);

  seq_state_t state, state_next;

  note_entry_t       rom_entry;
  logic [FREQ_W-1:0] freqReg;
  logic [DUR_W-1:0]  durCnt;
  logic [TICK_W-1:0] tick_count;
  logic [TICK_W-1:0] tick_last;
  logic [TICK_W-1:0] align_cnt;
  logic              tick;
  logic              start_accept;
  logic              align_go;
  logic              ramp_up;
  logic              ramp_down;
  logic              ramp_clear;
  logic [AMP_W-1:0]  ramp_step;
  logic [AMP_W-1:0]  level;
  logic              at_max;
  logic              at_min;

  assign rom_entry.freq = noteFrequency;
  assign rom_entry.dur  = noteDuration;

  assign start_accept = (state == IDLE) && start && !stop;
  assign tick         = busy && (tick_count == tick_last);

  // Phase-aligned note change; a silent generator (frequency 0) never
  // produces indexZero, and the counter guards against a stalled generator.
  assign align_go = indexZero || (outputFrequency == '0) || (align_cnt == ALIGN_LAST);

`ifdef NOTE_SEQUENCER_TEMPO_EN
  logic [31:0]       tempo_period;
  logic [TICK_W-1:0] tick_last_next;

  assign tempo_period   = 32'(TICK_DIV) >> tempoSelect;
  assign tick_last_next = (tempo_period > 32'd1) ? TICK_W'(tempo_period - 32'd1) : '0;

  // The period only changes at a wrap (or a fresh start), so a tick in
  // progress is never cut short.
  always_ff @(posedge CLK_32KHz or negedge reset_n) begin
    if (!reset_n) begin
      tick_last <= TICK_W'(TICK_DIV - 1);
    end else if (start_accept || tick) begin
      tick_last <= tick_last_next;
    end
  end
`else
  assign tick_last = TICK_W'(TICK_DIV - 1);
`endif

  // Tick divider: free-runs while a song is active, restarts on start.
  always_ff @(posedge CLK_32KHz or negedge reset_n) begin
    if (!reset_n) begin
      tick_count <= '0;
    end else if (start_accept) begin
      tick_count <= '0;
    end else if (busy) begin
      tick_count <= tick ? '0 : tick_count + TICK_W'(1);
    end
  end

  // Cycles spent waiting in ALIGN for the deadlock guard.
  always_ff @(posedge CLK_32KHz or negedge reset_n) begin
    if (!reset_n) begin
      align_cnt <= '0;
    end else if (state == ALIGN) begin
      align_cnt <= align_cnt + TICK_W'(1);
    end else begin
      align_cnt <= '0;
    end
  end

  // FSM state register.
  always_ff @(posedge CLK_32KHz or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic. Envelope exits look at the current level and
  // duration, so they fire the cycle after the tick that caused them;
  // running out of duration beats reaching full scale.
  always_comb begin
    state_next = state;
    if (stop) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_next = FETCH;
        FETCH:   state_next = LOAD;
        LOAD:    state_next = (rom_entry.dur == '0) ? END : ALIGN;
        ALIGN:   if (align_go) state_next = ATTACK;
        ATTACK: begin
          if (durCnt == '0) begin
            state_next = RELEASE;
          end else if (at_max) begin
            state_next = SUSTAIN;
          end
        end
        SUSTAIN: if (durCnt == '0) state_next = RELEASE;
        RELEASE: if (at_min) state_next = ADVANCE;
        ADVANCE: state_next = (noteAddress == ADDR_LAST) ? END : FETCH;
        END:     state_next = loopEnable ? FETCH : IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // FSM outputs and envelope controls.
  always_comb begin
    busy       = (state != IDLE);
    songDone   = (state == END) && !stop;
    ramp_up    = (state == ATTACK) && (durCnt != '0);
    ramp_down  = (state == RELEASE);
    ramp_clear = stop;
    ramp_step  = ramp_up ? AMP_W'(ATTACK_STEP) : AMP_W'(RELEASE_STEP);
  end

  // Note datapath: ROM address, latched note, duration countdown and the
  // frequency handed to the generator.
  always_ff @(posedge CLK_32KHz or negedge reset_n) begin
    if (!reset_n) begin
      noteAddress     <= '0;
      freqReg         <= '0;
      durCnt          <= '0;
      outputFrequency <= '0;
    end else if (stop) begin
      outputFrequency <= '0;
    end else begin
      case (state)
        IDLE:  if (start) noteAddress <= '0;
        LOAD: begin
          freqReg <= rom_entry.freq;
          durCnt  <= rom_entry.dur;
        end
        ALIGN: if (align_go) outputFrequency <= freqReg;
        ATTACK, SUSTAIN: begin
          if (tick && (durCnt != '0)) durCnt <= durCnt - DUR_W'(1);
        end
        ADVANCE: begin
          if (noteAddress != ADDR_LAST) noteAddress <= noteAddress + ADDR_W'(1);
        end
        END: begin
          if (loopEnable) begin
            noteAddress <= '0;
          end else begin
            outputFrequency <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  envelope_ramp u_envelope (
    .CLK_32KHz (CLK_32KHz),
    .reset_n   (reset_n),
    .tick      (tick),
    .rampUp    (ramp_up),
    .rampDown  (ramp_down),
    .step      (ramp_step),
    .clear     (ramp_clear),
    .level     (level),
    .atMax     (at_max),
    .atMin     (at_min)
  );

  // A rest still runs its envelope for timing but stays silent.
  assign outputAmplitude = (freqReg == '0) ? '0 : level;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed testbench for note_sequencer with TICK_DIV=4. A small synchronous
// ROM model feeds the DUT; expected values are hand-computed cycle offsets
// counted from the clock edge that accepts start (edge 0).
module tb_note_sequencer;
  import music_box_pkg::*;

  logic              CLK_32KHz = 1'b0;
  logic              reset_n   = 1'b0;
  logic              start     = 1'b0;
  logic              stop      = 1'b0;
  logic              loopEnable = 1'b0;
  logic              indexZero = 1'b0;
`ifdef NOTE_SEQUENCER_TEMPO_EN
  logic [1:0]        tempoSelect = 2'd0;
`endif
  logic [3:0]        noteAddress;
  logic [FREQ_W-1:0] noteFrequency;
  logic [DUR_W-1:0]  noteDuration;
  logic [FREQ_W-1:0] outputFrequency;
  logic [AMP_W-1:0]  outputAmplitude;
  logic              busy;
  logic              songDone;

  logic [FREQ_W-1:0] romFreq [16];
  logic [DUR_W-1:0]  romDur  [16];

  int vectorCount = 0;
  int miscompareCount = 0;
  int cyc = 0;
  int doneCount = 0;
  int busyDrops = 0;
  bit busyWatch = 1'b0;
  int maxAmp;
  int savedDone;

  note_sequencer #(
    .NOTE_COUNT   (16),
    .TICK_DIV     (4),
    .ATTACK_STEP  (16),
    .RELEASE_STEP (8)
  ) dut (
    .CLK_32KHz       (CLK_32KHz),
    .reset_n         (reset_n),
    .start           (start),
    .stop            (stop),
    .loopEnable      (loopEnable),
    .indexZero       (indexZero),
`ifdef NOTE_SEQUENCER_TEMPO_EN
    .tempoSelect     (tempoSelect),
`endif
    .noteAddress     (noteAddress),
    .noteFrequency   (noteFrequency),
    .noteDuration    (noteDuration),
    .outputFrequency (outputFrequency),
    .outputAmplitude (outputAmplitude),
    .busy            (busy),
    .songDone        (songDone)
  );

  always #5 CLK_32KHz = ~CLK_32KHz;

  // Synchronous ROM: data follows the address one cycle later.
  always @(posedge CLK_32KHz) begin
    noteFrequency <= romFreq[noteAddress];
    noteDuration  <= romDur[noteAddress];
  end

  // Event monitors sampled on the closing edge of each cycle.
  always @(posedge CLK_32KHz) begin
    if (songDone) doneCount++;
    if (busyWatch && !busy) busyDrops++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vectorCount++;
    if (observed !== expected) begin
      miscompareCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic loadRom(input int f0, input int d0, input int f1, input int d1,
                         input int f2, input int d2);
    for (int i = 0; i < 16; i++) begin
      romFreq[i] = '0;
      romDur[i]  = '0;
    end
    romFreq[0] = FREQ_W'(f0); romDur[0] = DUR_W'(d0);
    romFreq[1] = FREQ_W'(f1); romDur[1] = DUR_W'(d1);
    romFreq[2] = FREQ_W'(f2); romDur[2] = DUR_W'(d2);
  endtask

  // Pulse start for one cycle; on return we sit in the cycle after edge 0.
  task automatic applyStimulus();
    @(negedge CLK_32KHz);
    start = 1'b1;
    @(negedge CLK_32KHz);
    start = 1'b0;
    cyc = 0;
    doneCount = 0;
  endtask

  task automatic advanceTo(input int k);
    while (cyc < k) begin
      @(negedge CLK_32KHz);
      cyc++;
    end
  endtask

  task automatic waitIdle(input string tag, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge CLK_32KHz);
      n++;
    end
    checkOutput(tag, busy, 0);
  endtask

  initial begin
    loadRom(0, 0, 0, 0, 0, 0);

    // Reset state
    repeat (2) @(negedge CLK_32KHz);
    checkOutput("reset amp", outputAmplitude, 0);
    checkOutput("reset freq", outputFrequency, 0);
    checkOutput("reset addr", noteAddress, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset songDone", songDone, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge CLK_32KHz);

    // Full envelope: {440,20} then end marker
    $display("[TB] full envelope note");
    loadRom(440, 20, 0, 0, 0, 0);
    applyStimulus();
    advanceTo(3);   checkOutput("t1 freq applied", outputFrequency, 440);
                    checkOutput("t1 amp before tick", outputAmplitude, 0);
    advanceTo(4);   checkOutput("t1 amp tick1", outputAmplitude, 16);
    advanceTo(8);   checkOutput("t1 amp tick2", outputAmplitude, 32);
    advanceTo(63);  checkOutput("t1 amp tick15", outputAmplitude, 240);
    advanceTo(64);  checkOutput("t1 amp saturate", outputAmplitude, 255);
    advanceTo(83);  checkOutput("t1 amp sustain end", outputAmplitude, 255);
    advanceTo(84);  checkOutput("t1 amp release1", outputAmplitude, 247);
    advanceTo(207); checkOutput("t1 amp release31", outputAmplitude, 7);
    advanceTo(208); checkOutput("t1 amp release32", outputAmplitude, 0);
    advanceTo(210); checkOutput("t1 addr advance", noteAddress, 1);
                    checkOutput("t1 busy", busy, 1);
    advanceTo(212); checkOutput("t1 songDone", songDone, 1);
    advanceTo(213); checkOutput("t1 busy falls", busy, 0);
                    checkOutput("t1 freq cleared", outputFrequency, 0);
                    checkOutput("t1 done count", doneCount, 1);

    // Short note releases from mid-attack: {1000,5}
    $display("[TB] short note");
    loadRom(1000, 5, 0, 0, 0, 0);
    applyStimulus();
    advanceTo(3);   checkOutput("t2 freq", outputFrequency, 1000);
    advanceTo(20);  checkOutput("t2 amp tick5", outputAmplitude, 80);
    advanceTo(23);  checkOutput("t2 amp hold", outputAmplitude, 80);
    advanceTo(24);  checkOutput("t2 amp release1", outputAmplitude, 72);
    advanceTo(59);  checkOutput("t2 amp release9", outputAmplitude, 8);
    advanceTo(60);  checkOutput("t2 amp release10", outputAmplitude, 0);
    advanceTo(64);  checkOutput("t2 songDone", songDone, 1);
    advanceTo(65);  checkOutput("t2 idle", busy, 0);

    // Two notes, indexZero held low: guard applies 800 after 4 ALIGN cycles
    $display("[TB] align guard");
    loadRom(500, 3, 800, 3, 0, 0);
    applyStimulus();
    advanceTo(3);   checkOutput("t3a freq note0", outputFrequency, 500);
    advanceTo(38);  checkOutput("t3a addr note1", noteAddress, 1);
    advanceTo(43);  checkOutput("t3a freq held", outputFrequency, 500);
    advanceTo(44);  checkOutput("t3a freq guard", outputFrequency, 800);
                    checkOutput("t3a amp restart", outputAmplitude, 0);
    advanceTo(48);  checkOutput("t3a amp note1", outputAmplitude, 16);
    waitIdle("t3a end", 100);

    // Same song, indexZero pulsed on the third ALIGN cycle
    $display("[TB] align on indexZero");
    applyStimulus();
    advanceTo(42);  checkOutput("t3b freq held", outputFrequency, 500);
    indexZero = 1'b1;
    advanceTo(43);
    indexZero = 1'b0;
                    checkOutput("t3b freq at index", outputFrequency, 800);
    waitIdle("t3b end", 100);

    // Looping two-note song
    $display("[TB] loop");
    loadRom(600, 1, 700, 1, 0, 0);
    loopEnable = 1'b1;
    applyStimulus();
    busyWatch = 1'b1;
    advanceTo(13);  checkOutput("t4 addr0", noteAddress, 0);
    advanceTo(14);  checkOutput("t4 addr1", noteAddress, 1);
    advanceTo(20);  checkOutput("t4 freq note1", outputFrequency, 700);
    advanceTo(34);  checkOutput("t4 addr marker", noteAddress, 2);
    advanceTo(36);  checkOutput("t4 songDone wrap1", songDone, 1);
    advanceTo(37);  checkOutput("t4 addr wrap", noteAddress, 0);
    advanceTo(43);  checkOutput("t4 freq note0 again", outputFrequency, 600);
    advanceTo(54);  checkOutput("t4 addr1 again", noteAddress, 1);
    advanceTo(76);  checkOutput("t4 songDone wrap2", songDone, 1);
    advanceTo(77);  checkOutput("t4 addr wrap2", noteAddress, 0);
                    checkOutput("t4 done count", doneCount, 2);
    busyWatch = 1'b0;
    checkOutput("t4 busy drops", busyDrops, 0);
    stop = 1'b1;
    advanceTo(78);
    stop = 1'b0;
    loopEnable = 1'b0;
                    checkOutput("t4 stop idle", busy, 0);
                    checkOutput("t4 stop freq", outputFrequency, 0);

    // Rest note then a real note
    $display("[TB] rest note");
    loadRom(0, 6, 900, 1, 0, 0);
    applyStimulus();
    maxAmp = 0;
    for (int k = 1; k <= 79; k++) begin
      advanceTo(k);
      if (int'(outputAmplitude) > maxAmp) maxAmp = int'(outputAmplitude);
    end
    checkOutput("t5 rest silent", maxAmp, 0);
    advanceTo(77 + 3);
    checkOutput("t5 next amp", outputAmplitude, 16);
    checkOutput("t5 next freq", outputFrequency, 900);
    waitIdle("t5 end", 100);

    // stop together with start in SUSTAIN
    $display("[TB] stop in sustain");
    loadRom(440, 40, 0, 0, 0, 0);
    applyStimulus();
    advanceTo(70);  checkOutput("t6 sustain amp", outputAmplitude, 255);
    stop  = 1'b1;
    start = 1'b1;
    advanceTo(71);  checkOutput("t6 stop busy", busy, 0);
                    checkOutput("t6 stop amp", outputAmplitude, 0);
                    checkOutput("t6 stop freq", outputFrequency, 0);
                    checkOutput("t6 stop songDone", songDone, 0);
    advanceTo(72);  checkOutput("t6 stop wins idle", busy, 0);
    stop  = 1'b0;
    start = 1'b0;
    advanceTo(74);  checkOutput("t6 no done", doneCount, 0);

    // Asynchronous reset in ATTACK
    $display("[TB] async reset");
    applyStimulus();
    advanceTo(10);  checkOutput("t7 attack amp", outputAmplitude, 32);
    savedDone = doneCount;
    #2 reset_n = 1'b0;
    #1;
    checkOutput("t7 reset amp", outputAmplitude, 0);
    checkOutput("t7 reset freq", outputFrequency, 0);
    checkOutput("t7 reset busy", busy, 0);
    checkOutput("t7 reset addr", noteAddress, 0);
    checkOutput("t7 no done", doneCount, savedDone);
    @(negedge CLK_32KHz);
    reset_n = 1'b1;
    repeat (2) @(negedge CLK_32KHz);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
    $finish;
  end

endmodule
